// File: rtl/vsynth_pkg.sv
// Shared voice-synth constants and the load scheduler state encoding.
package vsynth_pkg;

  localparam int unsigned NUM_VOICES_DEF = 16;
  localparam int unsigned VOICE_W        = 4;
  localparam int unsigned WTB_NUM_W      = 5;
  localparam int unsigned WTB_RAM_SIZE   = 61;
  localparam int unsigned CNT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after 'start', wrapping.
module rr_arbiter
  import vsynth_pkg::*;
#(
  parameter int unsigned N = NUM_VOICES_DEF
) (
  input  logic [N-1:0]       req,
  input  logic [VOICE_W-1:0] start,
  output logic [N-1:0]       grant,
  output logic [VOICE_W-1:0] grant_idx,
  output logic               valid
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(start) + i) % N;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = VOICE_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wavetable_load_scheduler.sv
// Queues per-voice wavetable load commands and issues them one at a time to the
// wavetable loader, holding each for a fixed window long enough to fill the RAM.
module wavetable_load_scheduler
  import vsynth_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = NUM_VOICES_DEF,
  parameter int unsigned LOAD_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic [VOICE_W-1:0]    load_voice,
  input  logic [WTB_NUM_W-1:0]  load_wtb,
  output logic                  wtb_load,
  output logic [WTB_NUM_W-1:0]  wtb_num,
  output logic [VOICE_W-1:0]    voice_num,
  output logic                  busy,
  output logic [NUM_VOICES-1:0] pending,
  output logic                  done,
  output logic [VOICE_W-1:0]    done_voice
);

  sched_state_e          state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [VOICE_W-1:0]    rr_start, rr_start_n;
  logic [NUM_VOICES-1:0] pend_clr, set_mask, pending_n;
  logic [WTB_NUM_W-1:0]  wtb_store [NUM_VOICES];
  logic                  wtb_load_n, busy_n, done_n;
  logic [WTB_NUM_W-1:0]  wtb_num_n;
  logic [VOICE_W-1:0]    voice_num_n, done_voice_n;

  logic [NUM_VOICES-1:0] arb_grant;
  logic [VOICE_W-1:0]    arb_idx;
  logic                  arb_valid;

  rr_arbiter #(.N(NUM_VOICES)) u_rr_arbiter (
    .req       (pending),
    .start     (rr_start),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rr_start   <= '0;
      pending    <= '0;
      wtb_load   <= 1'b0;
      wtb_num    <= '0;
      voice_num  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_voice <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rr_start   <= rr_start_n;
      pending    <= pending_n;
      wtb_load   <= wtb_load_n;
      wtb_num    <= wtb_num_n;
      voice_num  <= voice_num_n;
      busy       <= busy_n;
      done       <= done_n;
      done_voice <= done_voice_n;
    end
  end

  // Latest request for a voice always wins its stored wavetable number.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) wtb_store[i] <= '0;
    end else if (load_req) begin
      wtb_store[load_voice] <= load_wtb;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    rr_start_n   = rr_start;
    pend_clr     = '0;
    wtb_load_n   = 1'b0;
    wtb_num_n    = wtb_num;
    voice_num_n  = voice_num;
    done_n       = 1'b0;
    done_voice_n = done_voice;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          state_n     = ST_ISSUE;
          pend_clr    = arb_grant;
          voice_num_n = arb_idx;
          wtb_num_n   = wtb_store[arb_idx];
          wtb_load_n  = 1'b1;
          rr_start_n  = (arb_idx == VOICE_W'(NUM_VOICES - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_n   = CNT_W'(LOAD_CYCLES - 1);
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // done is raised in the cycle the counter sits at zero; IDLE follows.
        if (cnt == '0) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            done_n       = 1'b1;
            done_voice_n = voice_num;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n    = (state_n != ST_IDLE);
    set_mask  = load_req ? (NUM_VOICES'(1) << load_voice) : '0;
    // A same-cycle request beats the grant's clear so the new wavetable reloads.
    pending_n = (pending & ~pend_clr) | set_mask;
  end

endmodule

// File: tb/tb_wavetable_load_scheduler.sv
// Directed bench for wavetable_load_scheduler: latency, round-robin order,
// overwrite/re-request behaviour and mid-load reset.
module tb_wavetable_load_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [3:0]  load_voice;
  logic [4:0]  load_wtb;
  logic        wtb_load;
  logic [4:0]  wtb_num;
  logic [3:0]  voice_num;
  logic        busy;
  logic [15:0] pending;
  logic        done;
  logic [3:0]  done_voice;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int n_done;
  int n_load;

  always #5 clk = ~clk;

  wavetable_load_scheduler #(.NUM_VOICES(16), .LOAD_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .load_voice (load_voice),
    .load_wtb   (load_wtb),
    .wtb_load   (wtb_load),
    .wtb_num    (wtb_num),
    .voice_num  (voice_num),
    .busy       (busy),
    .pending    (pending),
    .done       (done),
    .done_voice (done_voice)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [3:0] v, input logic [4:0] w);
    load_req   = 1'b1;
    load_voice = v;
    load_wtb   = w;
  endtask

  task automatic wait_load(output int cycles);
    cycles = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (wtb_load) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (done) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; load_voice = '0; load_wtb = '0;
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_wtb_load", 32'(wtb_load), 0);
    rst = 1'b0;
    step();

    // Single request: voice 3, wtb 0x05
    post(4'd3, 5'h05); step(); load_req = 1'b0;
    check("single_pend", 32'(pending), 32'h0008);
    check("single_noload_yet", 32'(wtb_load), 0);
    step();
    check("single_load", 32'(wtb_load), 1);
    check("single_voice", 32'(voice_num), 3);
    check("single_wtb", 32'(wtb_num), 5);
    check("single_busy", 32'(busy), 1);
    check("single_pend_clr", 32'(pending), 0);
    step();
    check("single_load_pulse", 32'(wtb_load), 0);
    wait_done(cyc);
    check("single_done_lat", 32'(cyc + 1), 64);
    check("single_done_voice", 32'(done_voice), 3);
    check("single_wtb_hold", 32'(wtb_num), 5);
    step();
    check("single_done_pulse", 32'(done), 0);
    check("single_idle", 32'(busy), 0);

    // Burst 2, 7, 0 in consecutive cycles
    post(4'd2, 5'h02); step();
    post(4'd7, 5'h07); step();
    check("burst_g0", 32'(voice_num), 2);
    check("burst_g0_load", 32'(wtb_load), 1);
    post(4'd0, 5'h10); step(); load_req = 1'b0;
    check("burst_pend", 32'(pending), 32'h0081);
    wait_load(cyc);
    check("burst_gap1", 32'(cyc + 1), 66);
    check("burst_g1", 32'(voice_num), 7);
    check("burst_g1_wtb", 32'(wtb_num), 7);
    wait_load(cyc);
    check("burst_gap2", 32'(cyc), 66);
    check("burst_g2", 32'(voice_num), 0);
    check("burst_g2_wtb", 32'(wtb_num), 5'h10);
    wait_done(cyc);
    check("burst_done_voice", 32'(done_voice), 0);
    step();
    check("burst_idle", 32'(busy), 0);

    // Overwrite: voice 5 posted twice while voice 1 is loading
    post(4'd1, 5'h03); step();
    post(4'd5, 5'h01); step();
    post(4'd5, 5'h1F); step(); load_req = 1'b0;
    check("ovr_pend", 32'(pending), 32'h0020);
    check("ovr_inflight", 32'(voice_num), 1);
    wait_load(cyc);
    check("ovr_gap", 32'(cyc), 65);
    check("ovr_voice", 32'(voice_num), 5);
    check("ovr_wtb", 32'(wtb_num), 5'h1F);
    check("ovr_pend_clr", 32'(pending), 0);
    wait_done(cyc);
    step(); step(); step();
    check("ovr_no_dup", 32'(busy), 0);

    // Request racing its own grant keeps the bit with the newer wtb
    post(4'd6, 5'h02); step();
    post(4'd6, 5'h03); step(); load_req = 1'b0;
    check("race_load", 32'(wtb_load), 1);
    check("race_wtb", 32'(wtb_num), 2);
    check("race_pend", 32'(pending), 32'h0040);
    wait_load(cyc);
    check("race_gap", 32'(cyc), 66);
    check("race_wtb2", 32'(wtb_num), 3);
    wait_done(cyc);
    step();

    // Re-request of the in-flight voice
    post(4'd4, 5'h09); step(); load_req = 1'b0;
    step();
    check("rereq_load", 32'(voice_num), 4);
    for (int i = 0; i < 10; i++) step();
    post(4'd4, 5'h0A); step(); load_req = 1'b0;
    check("rereq_pend", 32'(pending), 32'h0010);
    check("rereq_hold_wtb", 32'(wtb_num), 9);
    check("rereq_hold_voice", 32'(voice_num), 4);
    wait_done(cyc);
    check("rereq_done_voice", 32'(done_voice), 4);
    wait_load(cyc);
    check("rereq_gap", 32'(cyc), 2);
    check("rereq_voice2", 32'(voice_num), 4);
    check("rereq_wtb2", 32'(wtb_num), 5'h0A);
    wait_done(cyc);
    step();

    // Reset in the middle of WAIT with three voices pending
    post(4'd8, 5'h01); step(); load_req = 1'b0;
    step();
    check("mid_load", 32'(wtb_load), 1);
    post(4'd9, 5'h02);  step();
    post(4'd10, 5'h03); step();
    post(4'd11, 5'h04); step(); load_req = 1'b0;
    for (int i = 0; i < 31; i++) step();
    check("mid_pend", 32'(pending), 32'h0E00);
    rst = 1'b1;
    post(4'd12, 5'h05);
    step();
    rst = 1'b0; load_req = 1'b0;
    check("mid_rst_pend", 32'(pending), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_load", 32'(wtb_load), 0);
    check("mid_rst_wtb", 32'(wtb_num), 0);
    check("mid_rst_voice", 32'(voice_num), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_dvoice", 32'(done_voice), 0);
    n_done = 0; n_load = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done) n_done++;
      if (wtb_load) n_load++;
    end
    check("mid_no_done", 32'(n_done), 0);
    check("mid_no_load", 32'(n_load), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
